// File: rtl/stopwatch_key_fsm_if.sv
// ---------------------------------------------------------------------------
// stopwatch_key_fsm_if
//   Bundles the key inputs and timer control outputs of stopwatch_key_fsm.
//
//   master : the key front end (drives sw_en/pause/clear/state, reads keys)
//   slave  : the timer / status side (drives keys, reads controls)
//
//   Signals
//     key_start_n  raw start/stop button, active-low, asynchronous
//     key_lap_n    raw lap/reset button, active-low, asynchronous
//     sw_en        timer count enable
//     pause        timer display freeze (lap hold)
//     clear        one-cycle timer clear pulse
//     state        mode: 00 IDLE, 01 RUN, 10 LAP, 11 STOP
//
//   Handshake: there is no valid/ready pair. The keys are level inputs
//   sampled every clock; sw_en/pause/state are levels valid every cycle;
//   clear is a single-cycle strobe that the timer must act on when seen.
// ---------------------------------------------------------------------------
interface stopwatch_key_fsm_if;
    logic       key_start_n;
    logic       key_lap_n;
    logic       sw_en;
    logic       pause;
    logic       clear;
    logic [1:0] state;

    modport master (
        input  key_start_n,
        input  key_lap_n,
        output sw_en,
        output pause,
        output clear,
        output state
    );

    modport slave (
        output key_start_n,
        output key_lap_n,
        input  sw_en,
        input  pause,
        input  clear,
        input  state
    );
endinterface

// File: rtl/stopwatch_key_fsm.sv
// ---------------------------------------------------------------------------
// stopwatch_key_fsm
//   Front end of the stopwatch timer. Samples two raw active-low buttons at
//   100 Hz, synchronises and debounces them, turns debounced presses into
//   one-cycle events and runs the IDLE/RUN/LAP/STOP mode machine that drives
//   the timer's sw_en, pause and clear controls.
//
//   Parameters
//     DEBOUNCE_TICKS  stable samples needed before a debounced level moves (>=1)
//     LONG_TICKS      lap-hold length for long-press clear (macro build only)
//
//   Ports
//     clk_100hz  100 Hz tick clock
//     rst_n      asynchronous active-low reset
//     bus        stopwatch_key_fsm_if.master (keys in, timer controls out,
//                FSM state out for status LEDs)
//
//   Build option
//     LONG_PRESS_CLEAR_EN : holding lap for LONG_TICKS cycles in RUN, LAP or
//     STOP forces IDLE with a clear pulse. Without it there is no hold
//     counter and the only way back to IDLE is a lap press in STOP.
// ---------------------------------------------------------------------------
module stopwatch_key_fsm #(
    parameter int DEBOUNCE_TICKS = 2,
    parameter int LONG_TICKS     = 200
) (
    input  logic                clk_100hz,
    input  logic                rst_n,
    stopwatch_key_fsm_if.master bus
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_LAP  = 2'b10;
    localparam logic [1:0] S_STOP = 2'b11;

    localparam int            DW      = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_TICKS - 1);

    // Bit 0 = start key, bit 1 = lap key throughout.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_prev;
    logic [1:0]    ev;
    logic [DW-1:0] db_cnt [2];

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       clear_d;
    logic       sw_en_q;
    logic       pause_q;
    logic       clear_q;
    logic       lp_fire;

    assign raw = {bus.key_lap_n, bus.key_start_n};

    // -----------------------------------------------------------------------
    // Synchroniser, debounce and press-event generation for both keys
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_100hz or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 2'b11;
            sync2     <= 2'b11;
            deb       <= 2'b11;
            deb_prev  <= 2'b11;
            ev        <= 2'b00;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            deb_prev <= deb;
            // Registered one cycle after the debounced fall; releases are ignored.
            ev       <= deb_prev & ~deb;
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == deb[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_LAST) begin
                    // This sample is the DEBOUNCE_TICKS-th consecutive difference.
                    deb[k]    <= sync2[k];
                    db_cnt[k] <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

`ifdef LONG_PRESS_CLEAR_EN
    // -----------------------------------------------------------------------
    // Long-press detector on the debounced lap level. Counts only outside
    // IDLE; disarms after firing and re-arms on the debounced release, so a
    // single hold can fire at most once.
    // -----------------------------------------------------------------------
    localparam int            LW      = $clog2(LONG_TICKS + 1);
    localparam logic [LW-1:0] LP_LAST = LW'(LONG_TICKS - 1);

    logic [LW-1:0] lp_cnt;
    logic          lp_armed;

    assign lp_fire = lp_armed && !deb[1] && (state_q != S_IDLE) && (lp_cnt == LP_LAST);

    always_ff @(posedge clk_100hz or negedge rst_n) begin
        if (!rst_n) begin
            lp_cnt   <= '0;
            lp_armed <= 1'b1;
        end else if (deb[1]) begin
            lp_cnt   <= '0;
            lp_armed <= 1'b1;
        end else if (state_q == S_IDLE) begin
            lp_cnt   <= '0;
        end else if (lp_fire) begin
            // Disarm even if a start event wins this cycle and discards it.
            lp_cnt   <= '0;
            lp_armed <= 1'b0;
        end else if (lp_armed && (lp_cnt != LP_LAST)) begin
            lp_cnt   <= lp_cnt + 1'b1;
        end
    end
`else
    assign lp_fire = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Mode FSM. Start has priority over both the long press and the lap
    // event; a lap event arriving with start is dropped.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        if (ev[0]) begin
            case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   state_d = S_STOP;
                S_LAP:   state_d = S_STOP;
                default: state_d = S_RUN;
            endcase
        end else if (lp_fire) begin
            state_d = S_IDLE;
            clear_d = 1'b1;
        end else if (ev[1]) begin
            case (state_q)
                S_RUN:   state_d = S_LAP;
                S_LAP:   state_d = S_RUN;
                S_STOP: begin
                    state_d = S_IDLE;
                    clear_d = 1'b1;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs are decoded from the next state so they move on the same edge.
    always_ff @(posedge clk_100hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sw_en_q <= 1'b0;
            pause_q <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sw_en_q <= (state_d == S_RUN) || (state_d == S_LAP);
            pause_q <= (state_d == S_LAP);
            clear_q <= clear_d;
        end
    end

    assign bus.state = state_q;
    assign bus.sw_en = sw_en_q;
    assign bus.pause = pause_q;
    assign bus.clear = clear_q;

endmodule

// File: tb/tb_stopwatch_key_fsm.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_key_fsm
//   Self-checking bench for stopwatch_key_fsm: reset, bounce rejection, the
//   full mode cycle, simultaneous presses, long holds, the long-press option
//   and a randomized press sequence checked against a mode-table model.
// ---------------------------------------------------------------------------
module tb_stopwatch_key_fsm;

    localparam int DB   = 2;
    localparam int LONG = 200;
    // Raw fall to state change: 2 sync + DB debounce + 1 event + 1 FSM edges.
    localparam int LAT  = 2 + DB + 2;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_LAP  = 2'b10;
    localparam logic [1:0] S_STOP = 2'b11;

    // ---------------- clock / reset ----------------
    logic clk_100hz = 1'b0;
    logic rst_n     = 1'b0;
    always #5 clk_100hz = ~clk_100hz;

    stopwatch_key_fsm_if bus();

    stopwatch_key_fsm #(
        .DEBOUNCE_TICKS(DB),
        .LONG_TICKS    (LONG)
    ) dut (
        .clk_100hz(clk_100hz),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    // ---------------- reference model (mode table) ----------------
    function automatic logic [1:0] model_next(input logic [1:0] s, input bit st, input bit lp);
        logic [1:0] n;
        n = s;
        if (st) begin
            if (s == S_IDLE || s == S_STOP) n = S_RUN;
            else                            n = S_STOP;
        end else if (lp) begin
            if (s == S_RUN)       n = S_LAP;
            else if (s == S_LAP)  n = S_RUN;
            else if (s == S_STOP) n = S_IDLE;
        end
        return n;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_100hz);
            #1;
        end
    endtask

    task automatic drive_keys(input logic s, input logic l);
        bus.key_start_n = s;
        bus.key_lap_n   = l;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_keys(1'b1, 1'b1);
        step(2);
        rst_n = 1'b1;
        step(DB + 4);
    endtask

    task automatic press_key(input bit st, input bit lp, input int hold, input int gap);
        drive_keys(!st, !lp);
        step(hold);
        drive_keys(1'b1, 1'b1);
        step(gap);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive_keys(1'b0, 1'b1);
        step(3);
        checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL reset_state got %b want %b", bus.state, S_IDLE); end
        checks++; if (bus.sw_en !== 1'b0)   begin errors++; $display("FAIL reset_sw_en got %b want 0", bus.sw_en); end
        checks++; if (bus.pause !== 1'b0)   begin errors++; $display("FAIL reset_pause got %b want 0", bus.pause); end
        checks++; if (bus.clear !== 1'b0)   begin errors++; $display("FAIL reset_clear got %b want 0", bus.clear); end
        rst_n = 1'b1;
        step(4);
        checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL reset_release_early got %b want %b", bus.state, S_IDLE); end
        step(2);
        checks++; if (bus.state !== S_RUN)  begin errors++; $display("FAIL reset_release_run got %b want %b", bus.state, S_RUN); end
        checks++; if (bus.sw_en !== 1'b1)   begin errors++; $display("FAIL reset_release_sw_en got %b want 1", bus.sw_en); end
        drive_keys(1'b1, 1'b1);
        step(10);
        // Reset asserted mid-debounce must act before the next clock edge.
        drive_keys(1'b0, 1'b1);
        step(LAT - 1);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL async_reset_state got %b want %b", bus.state, S_IDLE); end
        checks++; if (bus.sw_en !== 1'b0)   begin errors++; $display("FAIL async_reset_sw_en got %b want 0", bus.sw_en); end
        do_reset();
    endtask

    task automatic test_bounce();
        do_reset();
        // Single-sample glitch must not produce an event.
        drive_keys(1'b0, 1'b1); step(1);
        drive_keys(1'b1, 1'b1); step(12);
        checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL glitch_ignored got %b want %b", bus.state, S_IDLE); end
        // Bouncing fall followed by a steady low.
        drive_keys(1'b0, 1'b1); step(1);
        drive_keys(1'b1, 1'b1); step(1);
        drive_keys(1'b0, 1'b1); step(1);
        drive_keys(1'b1, 1'b1); step(1);
        drive_keys(1'b0, 1'b1);
        step(LAT - 1);
        checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL bounce_early got %b want %b", bus.state, S_IDLE); end
        step(1);
        checks++; if (bus.state !== S_RUN)  begin errors++; $display("FAIL bounce_run got %b want %b", bus.state, S_RUN); end
        step(30);
        checks++; if (bus.state !== S_RUN)  begin errors++; $display("FAIL bounce_single_event got %b want %b", bus.state, S_RUN); end
        drive_keys(1'b1, 1'b1);
        step(10);
    endtask

    task automatic test_cycle();
        bit         seq_st [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0] seq_exp[5] = '{S_RUN, S_LAP, S_RUN, S_STOP, S_IDLE};
        logic [1:0] cur;
        do_reset();
        cur = S_IDLE;
        for (int i = 0; i < 5; i++) begin
            drive_keys(!seq_st[i], seq_st[i]);
            step(LAT - 1);
            checks++; if (bus.state !== cur) begin errors++; $display("FAIL cycle%0d_hold got %b want %b", i, bus.state, cur); end
            step(1);
            checks++; if (bus.state !== seq_exp[i]) begin errors++; $display("FAIL cycle%0d_state got %b want %b", i, bus.state, seq_exp[i]); end
            checks++; if (bus.pause !== (seq_exp[i] == S_LAP)) begin errors++; $display("FAIL cycle%0d_pause got %b want %b", i, bus.pause, seq_exp[i] == S_LAP); end
            checks++; if (bus.sw_en !== (seq_exp[i] == S_RUN || seq_exp[i] == S_LAP)) begin errors++; $display("FAIL cycle%0d_sw_en got %b", i, bus.sw_en); end
            checks++; if (bus.clear !== (seq_exp[i] == S_IDLE)) begin errors++; $display("FAIL cycle%0d_clear got %b want %b", i, bus.clear, seq_exp[i] == S_IDLE); end
            step(1);
            checks++; if (bus.clear !== 1'b0) begin errors++; $display("FAIL cycle%0d_clear_one_cycle got %b want 0", i, bus.clear); end
            step(8);
            drive_keys(1'b1, 1'b1);
            step(10);
            cur = seq_exp[i];
        end
    endtask

    task automatic test_simultaneous();
        bit lap_seen;
        do_reset();
        press_key(1'b1, 1'b0, LAT + 4, 10);
        checks++; if (bus.state !== S_RUN) begin errors++; $display("FAIL simul_setup got %b want %b", bus.state, S_RUN); end
        lap_seen = 1'b0;
        drive_keys(1'b0, 1'b0);
        for (int i = 1; i <= LAT + 10; i++) begin
            step(1);
            if (bus.state == S_LAP) lap_seen = 1'b1;
            if (i == LAT) begin
                checks++; if (bus.state !== S_STOP) begin errors++; $display("FAIL simul_stop got %b want %b", bus.state, S_STOP); end
            end
        end
        checks++; if (lap_seen !== 1'b0) begin errors++; $display("FAIL simul_no_lap got %b want 0", lap_seen); end
        drive_keys(1'b1, 1'b1);
        step(10);
    endtask

    task automatic test_hold();
        int clr_cnt;
        do_reset();
        press_key(1'b1, 1'b0, 10, 10);
        press_key(1'b1, 1'b0, 10, 10);
        checks++; if (bus.state !== S_STOP) begin errors++; $display("FAIL hold_setup got %b want %b", bus.state, S_STOP); end
        drive_keys(1'b1, 1'b0);
        step(LAT);
        checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL hold_idle got %b want %b", bus.state, S_IDLE); end
        checks++; if (bus.clear !== 1'b1)   begin errors++; $display("FAIL hold_clear got %b want 1", bus.clear); end
        clr_cnt = 0;
        for (int i = LAT + 1; i <= 500; i++) begin
            step(1);
            if (bus.clear) clr_cnt++;
        end
        checks++; if (clr_cnt !== 0)        begin errors++; $display("FAIL hold_extra_clear got %0d want 0", clr_cnt); end
        checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL hold_end got %b want %b", bus.state, S_IDLE); end
        drive_keys(1'b1, 1'b1);
        step(10);
    endtask

    task automatic test_long_press();
        logic [1:0] want_end;
        logic       want_clr;
        int         clr_cnt;
        localparam int FIRE = 2 + DB + LONG;
`ifdef LONG_PRESS_CLEAR_EN
        want_end = S_IDLE;
        want_clr = 1'b1;
`else
        want_end = S_LAP;
        want_clr = 1'b0;
`endif
        do_reset();
        press_key(1'b1, 1'b0, 10, 10);
        drive_keys(1'b1, 1'b0);
        step(LAT);
        checks++; if (bus.state !== S_LAP) begin errors++; $display("FAIL long_lap got %b want %b", bus.state, S_LAP); end
        step(FIRE - 1 - LAT);
        checks++; if (bus.state !== S_LAP) begin errors++; $display("FAIL long_before got %b want %b", bus.state, S_LAP); end
        step(1);
        checks++; if (bus.state !== want_end) begin errors++; $display("FAIL long_fire_state got %b want %b", bus.state, want_end); end
        checks++; if (bus.clear !== want_clr) begin errors++; $display("FAIL long_fire_clear got %b want %b", bus.clear, want_clr); end
        clr_cnt = 0;
        for (int i = FIRE + 1; i <= 250; i++) begin
            step(1);
            if (bus.clear) clr_cnt++;
        end
        checks++; if (clr_cnt !== 0)          begin errors++; $display("FAIL long_once got %0d want 0", clr_cnt); end
        checks++; if (bus.state !== want_end) begin errors++; $display("FAIL long_end got %b want %b", bus.state, want_end); end
        drive_keys(1'b1, 1'b1);
        step(10);
    endtask

    task automatic test_random();
        logic [1:0] cur;
        logic [1:0] e;
        int         op;
        int         hold;
        int         gap;
        bit         st;
        bit         lp;
        do_reset();
        cur = S_IDLE;
        for (int n = 0; n < 40; n++) begin
            op   = $urandom_range(0, 2);
            st   = (op != 1);
            lp   = (op != 0);
            hold = $urandom_range(8, 30);
            gap  = $urandom_range(6, 14);
            exp_q.push_back(model_next(cur, st, lp));
            drive_keys(!st, !lp);
            step(LAT - 1);
            checks++; if (bus.state !== cur) begin errors++; $display("FAIL rand%0d_hold got %b want %b", n, bus.state, cur); end
            step(1);
            e = exp_q.pop_front();
            checks++; if (bus.state !== e) begin errors++; $display("FAIL rand%0d_state op %0d got %b want %b", n, op, bus.state, e); end
            checks++; if (bus.sw_en !== (e == S_RUN || e == S_LAP)) begin errors++; $display("FAIL rand%0d_sw_en got %b", n, bus.sw_en); end
            checks++; if (bus.pause !== (e == S_LAP)) begin errors++; $display("FAIL rand%0d_pause got %b", n, bus.pause); end
            checks++; if (bus.clear !== (cur == S_STOP && e == S_IDLE)) begin errors++; $display("FAIL rand%0d_clear got %b", n, bus.clear); end
            step(hold - LAT);
            checks++; if (bus.state !== e) begin errors++; $display("FAIL rand%0d_stable got %b want %b", n, bus.state, e); end
            drive_keys(1'b1, 1'b1);
            step(gap);
            cur = e;
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        drive_keys(1'b1, 1'b1);
        test_reset();
        test_bounce();
        test_cycle();
        test_simultaneous();
        test_hold();
        test_long_press();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
